// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD accelerator: FSM states, algorithm
// selectors and the sizing helper for the binary-GCD shift counter.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  localparam int GCD_MODE_SUB = 0;
  localparam int GCD_MODE_BIN = 1;

  // Bits needed to count common factors of two, 0..WIDTH inclusive.
  function automatic int k_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/gcd_if.sv
// Operand/result stream bundle between a producer, the GCD engine and a consumer.
interface gcd_if #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 2 * WIDTH
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_gcd;
  logic [ITER_W-1:0] out_iters;
  logic              busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_gcd, out_iters, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_gcd, out_iters, busy
  );

endinterface

// File: rtl/gcd_step.sv
// One GCD iteration: combinational next values for a, b and k, plus the
// termination flag and the final (shift-corrected) result.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = GCD_MODE_SUB,
  parameter int KW    = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] a_nxt_o,
  output logic [WIDTH-1:0] b_nxt_o,
  output logic [KW-1:0]    k_nxt_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam bit BIN = (MODE == GCD_MODE_BIN);

  logic [WIDTH-1:0] base;

  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // priority chain leaves a value unassigned and infers a latch.
    a_nxt_o = a_i;
    b_nxt_o = b_i;
    k_nxt_o = k_i;
    done_o  = 1'b0;
    base    = a_i;

    if (a_i == '0) begin
      done_o = 1'b1;
      base   = b_i;
    end else if (b_i == '0 || a_i == b_i) begin
      done_o = 1'b1;
    end else if (BIN && !a_i[0] && !b_i[0]) begin
      a_nxt_o = a_i >> 1;
      b_nxt_o = b_i >> 1;
      k_nxt_o = k_i + KW'(1);
    end else if (BIN && !a_i[0]) begin
      a_nxt_o = a_i >> 1;
    end else if (BIN && !b_i[0]) begin
      b_nxt_o = b_i >> 1;
    end else if (a_i > b_i) begin
      a_nxt_o = a_i - b_i;
    end else begin
      b_nxt_o = b_i - a_i;
    end

    // Restoring the common powers of two cannot exceed max(A,B), so the
    // truncation to WIDTH bits never loses a set bit.
    result_o = BIN ? (base << k_i) : base;
  end

endmodule

// File: rtl/gcd_engine.sv
// Stream GCD accelerator: accepts an operand pair, iterates one step per
// cycle, then holds gcd and iteration count until the consumer takes them.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MODE   = GCD_MODE_SUB,
  parameter int ITER_W = 2 * WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  gcd_if.slave  bus
);

  localparam int KW = k_width(WIDTH);

  gcd_state_e        state_q;
  logic [WIDTH-1:0]  a_q, b_q, gcd_q;
  logic [KW-1:0]     k_q;
  logic [ITER_W-1:0] iters_q, out_iters_q;

  logic [WIDTH-1:0]  a_d, b_d, result;
  logic [KW-1:0]     k_d;
  logic              step_done;
  logic [ITER_W-1:0] iters_d;

  gcd_step #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .KW    (KW)
  ) u_step (
    .a_i      (a_q),
    .b_i      (b_q),
    .k_i      (k_q),
    .a_nxt_o  (a_d),
    .b_nxt_o  (b_d),
    .k_nxt_o  (k_d),
    .done_o   (step_done),
    .result_o (result)
  );

  // The count includes the CALC cycle that finds the result.
  assign iters_d = (iters_q == {ITER_W{1'b1}}) ? iters_q : iters_q + ITER_W'(1);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      iters_q     <= '0;
      gcd_q       <= '0;
      out_iters_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q     <= bus.in_a;
          b_q     <= bus.in_b;
          k_q     <= '0;
          iters_q <= '0;
          state_q <= CALC;
        end
        CALC: begin
          a_q     <= a_d;
          b_q     <= b_d;
          k_q     <= k_d;
          iters_q <= iters_d;
          if (step_done) begin
            gcd_q       <= result;
            out_iters_q <= iters_d;
            state_q     <= DONE;
          end
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == CALC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_gcd   = gcd_q;
  assign bus.out_iters = out_iters_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench: three engines (subtractive, binary, subtractive with a
// 4-bit iteration counter) compared every cycle against a behavioural model.
module tb_gcd_engine;
  import gcd_pkg::*;

  localparam int W  = 8;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv[ND];
  logic [W-1:0] ia[ND], ib[ND];
  logic         ordy[ND];
  logic         ir[ND], ov[ND], bsy[ND];
  logic [W-1:0] og[ND];
  logic [15:0]  oi[ND];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  gcd_if #(.WIDTH(W), .ITER_W(16)) if0 ();
  gcd_if #(.WIDTH(W), .ITER_W(16)) if1 ();
  gcd_if #(.WIDTH(W), .ITER_W(4))  if2 ();

  gcd_engine #(.WIDTH(W), .MODE(GCD_MODE_SUB), .ITER_W(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  gcd_engine #(.WIDTH(W), .MODE(GCD_MODE_BIN), .ITER_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  gcd_engine #(.WIDTH(W), .MODE(GCD_MODE_SUB), .ITER_W(4))  dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.in_valid = iv[0]; assign if0.in_a = ia[0]; assign if0.in_b = ib[0]; assign if0.out_ready = ordy[0];
  assign if1.in_valid = iv[1]; assign if1.in_a = ia[1]; assign if1.in_b = ib[1]; assign if1.out_ready = ordy[1];
  assign if2.in_valid = iv[2]; assign if2.in_a = ia[2]; assign if2.in_b = ib[2]; assign if2.out_ready = ordy[2];

  assign ir[0] = if0.in_ready; assign ov[0] = if0.out_valid; assign bsy[0] = if0.busy;
  assign og[0] = if0.out_gcd;  assign oi[0] = if0.out_iters;
  assign ir[1] = if1.in_ready; assign ov[1] = if1.out_valid; assign bsy[1] = if1.busy;
  assign og[1] = if1.out_gcd;  assign oi[1] = if1.out_iters;
  assign ir[2] = if2.in_ready; assign ov[2] = if2.out_valid; assign bsy[2] = if2.busy;
  assign og[2] = if2.out_gcd;  assign oi[2] = {12'd0, if2.out_iters};

  function automatic int mode_of(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic int itmax(input int d);
    return (d == 2) ? 15 : 65535;
  endfunction

  // Algorithm as stated: returns the gcd and the number of CALC cycles.
  function automatic void ref_gcd(input int mode, input int a0, input int b0,
                                  output logic [7:0] g, output int n);
    int a, b, k;
    a = a0; b = b0; k = 0; n = 0; g = 8'd0;
    for (int s = 1; s <= 1000; s++) begin
      n = s;
      if (a == 0)      begin g = 8'((b * (2 ** k)) % 256); return; end
      else if (b == 0) begin g = 8'((a * (2 ** k)) % 256); return; end
      else if (a == b) begin g = 8'((a * (2 ** k)) % 256); return; end
      else if (mode == 1 && a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; k++; end
      else if (mode == 1 && a % 2 == 0) a = a / 2;
      else if (mode == 1 && b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else b = b - a;
    end
  endfunction

  function automatic int euclid(input int a0, input int b0);
    int a, b, t;
    a = a0; b = b0;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Cycle-level transaction model: state 0 idle, 1 computing, 2 holding result.
  int           m_st[ND], m_left[ND], m_pn[ND], m_it[ND];
  logic [W-1:0] m_pg[ND], m_gcd[ND];
  logic [W-1:0] tg;
  int           tn;

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        m_st[d] <= 0; m_left[d] <= 0; m_gcd[d] <= '0; m_it[d] <= 0;
      end else begin
        case (m_st[d])
          0: if (iv[d]) begin
            ref_gcd(mode_of(d), int'(ia[d]), int'(ib[d]), tg, tn);
            m_pg[d] <= tg; m_pn[d] <= tn; m_left[d] <= tn; m_st[d] <= 1;
          end
          1: begin
            m_left[d] <= m_left[d] - 1;
            if (m_left[d] == 1) begin
              m_st[d]  <= 2;
              m_gcd[d] <= m_pg[d];
              m_it[d]  <= (m_pn[d] > itmax(d)) ? itmax(d) : m_pn[d];
            end
          end
          default: if (ordy[d]) m_st[d] <= 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < ND; d++) begin
        check($sformatf("cycle_dut%0d {in_ready,out_valid,busy,gcd,iters}", d),
              64'({ir[d], ov[d], bsy[d], og[d], oi[d]}),
              64'({m_st[d] == 0, m_st[d] == 2, m_st[d] == 1, m_gcd[d], 16'(m_it[d])}));
      end
    end
  end

  task automatic start_txn(input int d, input logic [7:0] a, input logic [7:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!ir[d] && w < 2000) begin @(negedge clk); w++; end
    check($sformatf("ready_wait_dut%0d", d), 64'(ir[d]), 64'(1));
    iv[d] = 1'b1; ia[d] = a; ib[d] = b;
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  // Latency counts cycles after the accept edge; the first CALC cycle is 1.
  task automatic wait_result(input int d, output logic [7:0] g, output int it, output int lat);
    lat = 1;
    while (!ov[d] && lat < 2000) begin @(negedge clk); lat++; end
    check($sformatf("valid_wait_dut%0d", d), 64'(ov[d]), 64'(1));
    g  = og[d];
    it = int'(oi[d]);
  endtask

  task automatic retire(input int d, input int hold);
    repeat (hold) @(negedge clk);
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
  endtask

  task automatic run_txn(input int d, input logic [7:0] a, input logic [7:0] b, input int hold,
                         output logic [7:0] g, output int it, output int lat);
    start_txn(d, a, b);
    wait_result(d, g, it, lat);
    retire(d, hold);
  endtask

  initial begin
    logic [7:0] g, ra, rb;
    int it, lat, d, n;

    rst = 1'b1;
    for (int i = 0; i < ND; i++) begin
      iv[i] = 1'b0; ia[i] = '0; ib[i] = '0; ordy[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_in_ready", 64'(ir[0]), 64'(1));
    check("reset_out_valid", 64'(ov[1]), 64'(0));
    check("reset_gcd_iters", 64'({og[2], oi[2]}), 64'(0));
    rst = 1'b0;

    // Pin the model to hand-derived values.
    ref_gcd(0, 12, 8, g, n);
    check("model_sub_12_8", 64'({g, 16'(n)}), 64'({8'd4, 16'd3}));
    ref_gcd(1, 12, 8, g, n);
    check("model_bin_12_8", 64'({g, 16'(n)}), 64'({8'd4, 16'd6}));
    ref_gcd(1, 0, 0, g, n);
    check("model_bin_0_0", 64'({g, 16'(n)}), 64'({8'd0, 16'd1}));

    run_txn(0, 8'd12, 8'd8, 0, g, it, lat);
    check("sub_12_8_gcd", 64'(g), 64'(4));
    check("sub_12_8_iters", 64'(it), 64'(3));
    check("sub_12_8_latency", 64'(lat), 64'(4));

    run_txn(1, 8'd12, 8'd8, 1, g, it, lat);
    check("bin_12_8_gcd", 64'(g), 64'(4));
    check("bin_12_8_iters", 64'(it), 64'(6));
    check("bin_12_8_latency", 64'(lat), 64'(7));

    for (int m = 0; m < 2; m++) begin
      run_txn(m, 8'd0, 8'd5, 0, g, it, lat);
      check($sformatf("zero_a_dut%0d", m), 64'({g, 16'(it), 16'(lat)}), 64'({8'd5, 16'd1, 16'd2}));
      run_txn(m, 8'd7, 8'd0, 0, g, it, lat);
      check($sformatf("zero_b_dut%0d", m), 64'(g), 64'(7));
      run_txn(m, 8'd0, 8'd0, 0, g, it, lat);
      check($sformatf("zero_both_dut%0d", m), 64'({g, 16'(it)}), 64'({8'd0, 16'd1}));
    end

    // Backpressure: result held, new operands ignored while the consumer stalls.
    start_txn(0, 8'd12, 8'd8);
    wait_result(0, g, it, lat);
    for (int c = 0; c < 10; c++) begin
      iv[0] = c[0]; ia[0] = 8'd3; ib[0] = 8'd9;
      @(negedge clk);
      check("stall_hold", 64'({og[0], ir[0], ov[0]}), 64'({8'd4, 1'b0, 1'b1}));
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    check("stall_release", 64'({ir[0], ov[0]}), 64'({1'b1, 1'b0}));

    // Reset in the middle of a long subtractive run.
    start_txn(0, 8'd255, 8'd1);
    repeat (49) @(negedge clk);
    check("pre_reset_busy", 64'(bsy[0]), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_idle", 64'({ir[0], ov[0], bsy[0]}), 64'({1'b1, 1'b0, 1'b0}));
    rst = 1'b0;
    run_txn(0, 8'd9, 8'd6, 0, g, it, lat);
    check("after_reset_9_6", 64'(g), 64'(3));

    run_txn(2, 8'd255, 8'd1, 0, g, it, lat);
    check("saturate_gcd", 64'(g), 64'(1));
    check("saturate_iters", 64'(it), 64'(15));

    for (int i = 0; i < 60; i++) begin
      d  = $urandom_range(0, 1);
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rb = 8'($urandom_range(0, 3));
      run_txn(d, ra, rb, $urandom_range(0, 3), g, it, lat);
      check($sformatf("rand_dut%0d_%0d_%0d", d, ra, rb), 64'(g), 64'(euclid(int'(ra), int'(rb))));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gcd_engine.md
# gcd_engine

Parametrised GCD accelerator with valid/ready handshakes on operand input and result output, selectable subtractive (Euclid) or binary (Stein) algorithm, and an iteration-count output. Controller and datapath are merged in one block, so the unit drops directly between a stream producer and consumer in the arithmetic subsystem. It supersedes the fixed-width, externally sequenced GCD datapath.

## Interface
- WIDTH, 8, operand and result width (≥2)
- MODE, 0, algorithm: 0 = subtractive, 1 = binary (Stein)
- ITER_W, 2*WIDTH, iteration-counter width (saturating)

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands present
- in_ready  out  1  engine idle, accepts operands
- in_a  in  WIDTH  operand A, unsigned
- in_b  in  WIDTH  operand B, unsigned
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_gcd  out  WIDTH  gcd(A,B)
- out_iters  out  ITER_W  CALC cycles spent on this result, saturating at 2^ITER_W−1
- busy  out  1  state is CALC

## Operation
- FSM states: IDLE → CALC → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready loads a←in_a, b←in_b, k←0, iters←0, then enters CALC.
- CALC: exactly one step per cycle; iters increments (saturating) every CALC cycle. Checks in priority order:
  - a==0: result=b<<k, go DONE.
  - b==0: result=a<<k, go DONE.
  - a==b: result=a<<k, go DONE.
  - MODE 1 only:
    - both even: a>>=1, b>>=1, k++.
    - else a even: a>>=1.
    - else b even: b>>=1.
  - Otherwise: larger ← larger − smaller.
- The k register is ⌈log2(WIDTH+1)⌉ bits and exists only for MODE 1; in MODE 0, k stays 0.
- The shift result is truncated to WIDTH bits. This cannot overflow, since gcd ≤ max(A,B).
- gcd(0,0)=0. gcd(0,x)=x.
- On the DONE transition, out_gcd and out_iters are loaded. They stay stable while out_valid=1.
- DONE:
  - out_valid=1, in_ready=0.
  - out_ready=1 returns to IDLE.
  - Otherwise the state holds indefinitely; the output is never overwritten.
- in_valid during CALC or DONE is ignored; it is not queued.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_gcd=0, out_iters=0, internal a/b/k/iters=0.
- Accept at edge t: busy=1 from t+1.
- First CALC cycle is t+1. If the result is found in CALC cycle n, out_valid=1 from cycle t+n+1.
- Minimum latency from accept to out_valid is 2 cycles (zero or equal operands).
- Handshake with out_ready at edge u: out_valid=0 and in_ready=1 from u+1. There is no same-cycle accept/retire bypass, so throughput is at most one result per n+2 cycles.
- rst during CALC or DONE: back to IDLE at the next edge. The in-flight result is discarded and out_valid drops.
- rst together with in_valid: rst wins; nothing is accepted.
- Worst case, MODE 0: gcd(2^WIDTH−1, 1) takes 2^WIDTH−1 CALC cycles.
- Worst case, MODE 1: bounded by about 2·WIDTH+2 CALC cycles.

## Structure
- Package gcd_pkg holds:
  - FSM state enum: IDLE, CALC, DONE.
  - Mode constants GCD_MODE_SUB=0 and GCD_MODE_BIN=1.
  - Width helper function for k.
- Sub-module gcd_step: purely combinational next-value logic. It takes a, b, k and MODE, and returns a_nxt, b_nxt, k_nxt, done and result.
- gcd_engine holds the FSM, the registers and the handshake logic.

## Test plan
- MODE 0, A=12, B=8:
  - out_gcd=4 and out_iters=3.
  - out_valid rises 4 cycles after the accept edge.
- MODE 1, A=12, B=8:
  - Step sequence (6,4,k1) → (3,2,k2) → (3,1) → (2,1) → (1,1).
  - out_gcd=4, out_iters=6.
- Zero operands, both modes:
  - (0,5) gives 5 with iters=1.
  - (7,0) gives 7.
  - (0,0) gives 0 with iters=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid.
  - Result is stable, in_ready=0, and new in_valid pulses are ignored.
  - Releasing out_ready gives in_ready=1 on the next cycle.
- Reset mid-CALC: MODE 0, A=255, B=1, assert rst at CALC cycle 50.
  - Next cycle shows IDLE, out_valid=0, in_ready=1.
  - A fresh (9,6) then yields 3.
- Saturation: WIDTH=8, ITER_W=4, MODE 0, A=255, B=1.
  - out_gcd=1, out_iters=15.
  - Random sweep against a reference-model gcd for both modes.
